// File: rtl/pulse_width_decoder.sv
// Pulse-width decoder: measures onset edge and width of the first pulse in each
// gamma-cycle window and presents the result on a valid/ready output register.
module pulse_width_decoder #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int W                 = $clog2(GAMMA_CYCLE_WIDTH + 1)
) (
  input  logic         aclk,
  input  logic         rst_n,
  input  logic         gamma_start,
  input  logic         pulse_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_onset,
  output logic [W-1:0] out_width,
  output logic         out_none,
  output logic         out_trunc,
  output logic         overflow
);

  // Handshake: a result transfers on any edge where out_valid && out_ready; while
  // out_valid=1 and out_ready=0 every output field holds stable.

  localparam logic [W-1:0] LAST = W'(GAMMA_CYCLE_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HIGH} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] t;
  logic [W-1:0] onset_q, width_q;
  logic         last_edge;

  logic         pub;
  logic [W-1:0] pub_onset, pub_width;
  logic         pub_none, pub_trunc;

  assign last_edge = (t == LAST);

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (gamma_start) begin
      state_nxt = S_ARMED;
    end else begin
      case (state)
        S_ARMED: begin
          if (last_edge)     state_nxt = S_IDLE;
          else if (pulse_in) state_nxt = S_HIGH;
        end
        S_HIGH: begin
          if (last_edge || !pulse_in) state_nxt = S_IDLE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Publish decode; gamma_start discards any in-flight measurement.
  always_comb begin
    pub       = 1'b0;
    pub_onset = '0;
    pub_width = '0;
    pub_none  = 1'b0;
    pub_trunc = 1'b0;
    if (!gamma_start) begin
      case (state)
        S_ARMED: begin
          if (last_edge) begin
            pub = 1'b1;
            if (pulse_in) begin
              pub_onset = LAST;
              pub_width = W'(1);
              pub_trunc = 1'b1;
            end else begin
              pub_none = 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (!pulse_in) begin
            pub       = 1'b1;
            pub_onset = onset_q;
            pub_width = width_q;
          end else if (last_edge) begin
            pub       = 1'b1;
            pub_onset = onset_q;
            pub_width = width_q + W'(1);
            pub_trunc = 1'b1;
          end
        end
        default: pub = 1'b0;
      endcase
    end
  end

  // Gamma counter and in-flight measurement.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      t       <= '0;
      onset_q <= '0;
      width_q <= '0;
    end else if (gamma_start) begin
      t       <= W'(1);
      onset_q <= '0;
      width_q <= '0;
    end else begin
      if (t != LAST) t <= t + W'(1);
      if (state == S_ARMED && pulse_in) begin
        onset_q <= t;
        width_q <= W'(1);
      end else if (state == S_HIGH && pulse_in) begin
        width_q <= width_q + W'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_onset <= '0;
      out_width <= '0;
      out_none  <= 1'b0;
      out_trunc <= 1'b0;
      overflow  <= 1'b0;
    end else if (pub) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_onset <= pub_onset;
        out_width <= pub_width;
        out_none  <= pub_none;
        out_trunc <= pub_trunc;
      end else begin
        overflow <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Directed bench for pulse_width_decoder with G=16: windows are driven edge by edge
// and results checked against hand-computed onset/width/flag values.
module tb_pulse_width_decoder;

  localparam int G = 16;
  localparam int W = 5;

  logic         aclk;
  logic         rst_n;
  logic         gamma_start;
  logic         pulse_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_onset;
  logic [W-1:0] out_width;
  logic         out_none;
  logic         out_trunc;
  logic         overflow;

  int n_cmp = 0;
  int n_err = 0;

  pulse_width_decoder #(.GAMMA_CYCLE_WIDTH(G)) dut (
    .aclk        (aclk),
    .rst_n       (rst_n),
    .gamma_start (gamma_start),
    .pulse_in    (pulse_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_onset   (out_onset),
    .out_width   (out_width),
    .out_none    (out_none),
    .out_trunc   (out_trunc),
    .overflow    (overflow)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic v, input int on, input int wid,
                         input logic none, input logic trunc);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".onset"}, 32'(out_onset), 32'(on));
    chk({tag, ".width"}, 32'(out_width), 32'(wid));
    chk({tag, ".none"},  32'(out_none),  32'(none));
    chk({tag, ".trunc"}, 32'(out_trunc), 32'(trunc));
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic step(input logic gs, input logic p, input logic rdy);
    gamma_start = gs;
    pulse_in    = p;
    out_ready   = rdy;
    @(posedge aclk);
    @(negedge aclk);
  endtask

  // Edge indices k0..k1 of a window; k=0 is the gamma_start edge.
  task automatic run_edges(input int k0, input int k1, input int on, input int wid,
                           input logic rdy);
    for (int k = k0; k <= k1; k++)
      step(k == 0, (k != 0) && (k >= on) && (k < on + wid), rdy);
  endtask

  initial begin
    rst_n = 1'b1; gamma_start = 1'b0; pulse_in = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_res("reset", 1'b0, 0, 0, 1'b0, 1'b0);
    chk("reset.overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge aclk);
    rst_n = 1'b1;
    @(negedge aclk);

    // IDLE ignores pulse_in until the first gamma_start
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    chk("idle_ignore.valid", 32'(out_valid), 32'd0);

    // Test 1: pulse E3..E8, falls at E9
    run_edges(0, 8, 3, 6, 1'b1);
    chk("t1_pre.valid", 32'(out_valid), 32'd0);
    run_edges(9, 9, 3, 6, 1'b1);
    chk_res("t1", 1'b1, 3, 6, 1'b0, 1'b0);
    run_edges(10, 10, 3, 6, 1'b1);
    chk("t1_accept.valid", 32'(out_valid), 32'd0);
    run_edges(11, 15, 3, 6, 1'b1);
    chk("t1_end.valid", 32'(out_valid), 32'd0);

    // Test 2: no pulse in window
    run_edges(0, 14, 0, 0, 1'b1);
    chk("t2_pre.valid", 32'(out_valid), 32'd0);
    run_edges(15, 15, 0, 0, 1'b1);
    chk_res("t2", 1'b1, 0, 0, 1'b1, 1'b0);

    // Test 3: pulse E10..E15, truncated
    run_edges(0, 14, 10, 6, 1'b1);
    chk("t3_pre.valid", 32'(out_valid), 32'd0);
    run_edges(15, 15, 10, 6, 1'b1);
    chk_res("t3", 1'b1, 10, 6, 1'b0, 1'b1);

    // Only the first pulse of a window is reported
    run_edges(0, 4, 2, 2, 1'b1);
    chk_res("first", 1'b1, 2, 2, 1'b0, 1'b0);
    run_edges(5, 15, 6, 2, 1'b1);
    chk("second_ignored.valid", 32'(out_valid), 32'd0);

    // Onset on the very last edge
    run_edges(0, 15, 15, 1, 1'b1);
    chk_res("last_onset", 1'b1, 15, 1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("drain1.valid", 32'(out_valid), 32'd0);

    // Test 5: publish coincides with accept
    run_edges(0, 15, 3, 6, 1'b0);
    chk_res("t5_a", 1'b1, 3, 6, 1'b0, 1'b0);
    run_edges(0, 7, 4, 4, 1'b0);
    chk_res("t5_hold", 1'b1, 3, 6, 1'b0, 1'b0);
    run_edges(8, 8, 4, 4, 1'b1);
    chk_res("t5_b", 1'b1, 4, 4, 1'b0, 1'b0);
    chk("t5.overflow", 32'(overflow), 32'd0);
    run_edges(9, 9, 4, 4, 1'b1);
    chk("t5_accept.valid", 32'(out_valid), 32'd0);
    run_edges(10, 15, 4, 4, 1'b1);

    // Test 4: stalled consumer across two windows
    run_edges(0, 15, 3, 6, 1'b0);
    chk_res("t4_a", 1'b1, 3, 6, 1'b0, 1'b0);
    chk("t4_a.overflow", 32'(overflow), 32'd0);
    run_edges(0, 15, 5, 2, 1'b0);
    chk_res("t4_hold", 1'b1, 3, 6, 1'b0, 1'b0);
    chk("t4.overflow", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("t4_drain.valid", 32'(out_valid), 32'd0);
    chk("t4_sticky.overflow", 32'(overflow), 32'd1);

    // Test 6a: gamma_start during HIGH restarts the window
    run_edges(0, 4, 2, 10, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("t6a_abort.valid", 32'(out_valid), 32'd0);
    run_edges(1, 4, 3, 2, 1'b1);
    chk("t6a_pre.valid", 32'(out_valid), 32'd0);
    run_edges(5, 5, 3, 2, 1'b1);
    chk_res("t6a", 1'b1, 3, 2, 1'b0, 1'b0);
    run_edges(6, 15, 3, 2, 1'b1);
    chk("t6a_end.valid", 32'(out_valid), 32'd0);

    // Test 6b: asynchronous reset mid-HIGH with a held result
    run_edges(0, 15, 3, 6, 1'b0);
    chk_res("t6b_held", 1'b1, 3, 6, 1'b0, 1'b0);
    run_edges(0, 4, 2, 10, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_res("t6b_reset", 1'b0, 0, 0, 1'b0, 1'b0);
    chk("t6b_reset.overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge aclk);
    rst_n = 1'b1;
    for (int k = 5; k <= 15; k++) begin
      step(1'b0, k < 12, 1'b1);
      chk("t6b_quiet.valid", 32'(out_valid), 32'd0);
    end
    run_edges(0, 5, 2, 3, 1'b1);
    chk_res("t6b_resume", 1'b1, 2, 3, 1'b0, 1'b0);
    run_edges(6, 6, 2, 3, 1'b1);
    chk("t6b_resume_accept.valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
